wallace_csa_accum: RTL and testbench

- Multi-cycle carry-save partial-product reducer for the mantissa multiplier.
- Accepts two unsigned WIDTH-bit operands and iteratively compresses their partial products with 3:2 CSA layers.
- Produces a redundant 2*WIDTH-bit sum/carry pair; the 40-bit carry-lookahead adder directly downstream resolves this pair into the product.
- Downstream adder has no Cin/Cout, so all arithmetic here is modulo 2^(2*WIDTH).

---
 rtl/wallace_csa_accum_pkg.sv | 15 +
 rtl/wallace_csa_accum_csa_3to2.sv | 19 +
 rtl/wallace_csa_accum.sv | 149 ++++++++++++++
 tb/tb_wallace_csa_accum.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wallace_csa_accum_pkg.sv
// Shared constants and FSM state type for the carry-save mantissa multiplier.
package wallace_csa_accum_pkg;

  localparam int MUL_W          = 20;
  localparam int PROD_W         = 2 * MUL_W;
  localparam int ROWS_PER_CYCLE = 4;
  localparam int N_GROUPS       = MUL_W / ROWS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/wallace_csa_accum_csa_3to2.sv
// Generic-width 3:2 carry-save row: bitwise full adders, carry pre-shifted to
// its weight and truncated to the vector width.
module csa_3to2 #(
  parameter int W = 40
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-1:0] w_maj;

  assign o_sum   = i_x ^ i_y ^ i_z;
  assign w_maj   = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
  assign o_carry = w_maj << 1;

endmodule

// File: rtl/wallace_csa_accum.sv
// Multi-cycle carry-save partial-product reducer producing a redundant sum/carry
// pair. Optional early exit on exhausted multiplier bits: WALLACE_ZERO_SKIP_EN.
module wallace_csa_accum #(
  parameter int WIDTH          = wallace_csa_accum_pkg::MUL_W,
  parameter int ROWS_PER_CYCLE = wallace_csa_accum_pkg::ROWS_PER_CYCLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_sum,
  output logic [2*WIDTH-1:0] out_carry
);

  import wallace_csa_accum_pkg::state_t;
  import wallace_csa_accum_pkg::IDLE;
  import wallace_csa_accum_pkg::ACCUM;
  import wallace_csa_accum_pkg::DONE;

  localparam int PW = 2 * WIDTH;
  localparam int NG = WIDTH / ROWS_PER_CYCLE;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NG - 1);

  if ((WIDTH % ROWS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of ROWS_PER_CYCLE");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [PW-1:0]   r_s;
  logic [PW-1:0]   r_c;
  logic            r_out_valid;
  logic            r_in_ready;

  logic [PW-1:0]   w_rows [ROWS_PER_CYCLE];
  logic [PW-1:0]   w_s_nxt;
  logic [PW-1:0]   w_c_nxt;
  logic            w_last;

  // Operands are pre-shifted each group so the current rows always sit at
  // multiplier bits [ROWS_PER_CYCLE-1:0] and multiplicand offset 0..R-1.
  always_comb begin
    // NOTE: default every element first so no path leaves a latch behind.
    w_rows = '{default: '0};
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      w_rows[k] = r_b_sh[k] ? (r_a_sh << k) : '0;
    end
  end

  if (ROWS_PER_CYCLE == 4) begin : g_tree
    logic [PW-1:0] w_s1a, w_c1a, w_s1b, w_c1b, w_s2, w_c2;

    csa_3to2 #(.W(PW)) u_l1a (.i_x(r_s),       .i_y(r_c),       .i_z(w_rows[0]),
                              .o_sum(w_s1a),   .o_carry(w_c1a));
    csa_3to2 #(.W(PW)) u_l1b (.i_x(w_rows[1]), .i_y(w_rows[2]), .i_z(w_rows[3]),
                              .o_sum(w_s1b),   .o_carry(w_c1b));
    csa_3to2 #(.W(PW)) u_l2  (.i_x(w_s1a),     .i_y(w_c1a),     .i_z(w_s1b),
                              .o_sum(w_s2),    .o_carry(w_c2));
    csa_3to2 #(.W(PW)) u_l3  (.i_x(w_s2),      .i_y(w_c2),      .i_z(w_c1b),
                              .o_sum(w_s_nxt), .o_carry(w_c_nxt));
  end else begin : g_chain
    logic [PW-1:0] w_s_ch [ROWS_PER_CYCLE+1];
    logic [PW-1:0] w_c_ch [ROWS_PER_CYCLE+1];

    assign w_s_ch[0] = r_s;
    assign w_c_ch[0] = r_c;
    for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_stage
      csa_3to2 #(.W(PW)) u_csa (.i_x(w_s_ch[k]), .i_y(w_c_ch[k]), .i_z(w_rows[k]),
                                .o_sum(w_s_ch[k+1]), .o_carry(w_c_ch[k+1]));
    end
    assign w_s_nxt = w_s_ch[ROWS_PER_CYCLE];
    assign w_c_nxt = w_c_ch[ROWS_PER_CYCLE];
  end

`ifdef WALLACE_ZERO_SKIP_EN
  assign w_last = (r_cnt == LAST_CNT) || ((r_b_sh >> ROWS_PER_CYCLE) == '0);
`else
  assign w_last = (r_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s        <= '0;
            r_c        <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          r_s   <= w_s_nxt;
          r_c   <= w_c_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // NOTE: operand registers carry no reset; IDLE always reloads them before use.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a_sh <= PW'(in_a);
      r_b_sh <= in_b;
    end else if (r_state == ACCUM) begin
      r_a_sh <= r_a_sh << ROWS_PER_CYCLE;
      r_b_sh <= r_b_sh >> ROWS_PER_CYCLE;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_s;
  assign out_carry = r_c;

endmodule

// File: tb/tb_wallace_csa_accum.sv
// Scoreboard bench for wallace_csa_accum: directed products, latency,
// backpressure, mid-operation reset and back-to-back issue.
module tb_wallace_csa_accum;
  import wallace_csa_accum_pkg::*;

`ifdef WALLACE_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int LAT_FULL = N_GROUPS;
  localparam int LAT_B1   = SKIP ? 1 : LAT_FULL;  // multiplier fits in group 0
  localparam int LAT_B10  = SKIP ? 2 : LAT_FULL;  // highest bit in group 1
  localparam int LAT_ABC  = SKIP ? 3 : LAT_FULL;  // highest bit in group 2
  // ACCUM cycles, one DONE cycle, one IDLE cycle between accepts.
  localparam int SPACING  = SKIP ? 3 : LAT_FULL + 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [MUL_W-1:0]  in_a;
  logic [MUL_W-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_sum;
  logic [PROD_W-1:0] out_carry;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [PROD_W-1:0] exp_q [$];

  wallace_csa_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [PROD_W-1:0] p;
      logic [PROD_W-1:0] e;
      p = out_sum + out_carry;
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", p);
      end else begin
        e = exp_q.pop_front();
        check("product", 64'(p), 64'(e));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic wait_accept(output int t);
    int  n  = 0;
    logic rb = 1'b0;
    do begin
      rb = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rb && n < 50);
    t = cyc;
    check("accept_seen", 64'(rb), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [MUL_W-1:0] a,
                        input logic [MUL_W-1:0] b, input logic [PROD_W-1:0] exp,
                        input int exp_lat, input int hold);
    int lat = 0;
    logic [PROD_W-1:0] s0, c0;
    wait_ready();
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (hold > 0) begin
      s0 = out_sum;
      c0 = out_carry;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({name, "_hold_sum"}, 64'(out_sum), 64'(s0));
        check({name, "_hold_carry"}, 64'(out_carry), 64'(c0));
      end
      check({name, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'(0));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, "_drop_valid"}, 64'(out_valid), 64'(0));
    check({name, "_in_ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t1, t2, n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_sum",   64'(out_sum),   64'(0));
    check("rst_out_carry", 64'(out_carry), 64'(0));

    run_op("one_x_one", 20'h00001, 20'h00001, 40'h0000000001, LAT_B1,   0);
    run_op("max_x_max", 20'hFFFFF, 20'hFFFFF, 40'hFFFFE00001, LAT_FULL, 0);
    run_op("backpress", 20'hFFFFF, 20'hFFFFF, 40'hFFFFE00001, LAT_FULL, 10);
    run_op("msb_x_msb", 20'h80000, 20'h80000, 40'h4000000000, LAT_FULL, 0);

    // Abort an operation during its third ACCUM cycle; nothing may come out.
    wait_ready();
    in_a     = 20'hFFFFF;
    in_b     = 20'hFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready",  64'(in_ready),  64'(1));
    check("abort_out_sum",   64'(out_sum),   64'(0));
    check("abort_out_carry", 64'(out_carry), 64'(0));
    run_op("after_abort", 20'h12345, 20'h00ABC, 40'h000C3698AC, LAT_ABC, 0);

    // Back-to-back with in_valid held high.
    wait_ready();
    out_ready = 1'b1;
    in_a      = 20'd3;
    in_b      = 20'd5;
    in_valid  = 1'b1;
    exp_q.push_back(40'd15);
    wait_accept(t1);
    in_a = 20'd7;
    in_b = 20'd9;
    exp_q.push_back(40'd63);
    wait_accept(t2);
    in_valid = 1'b0;
    check("b2b_spacing", 64'(t2 - t1), 64'(SPACING));
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;

    run_op("b_three",   20'h12345, 20'h00003, 40'h00000369CF, LAT_B1,  0);
    run_op("b_zero",    20'hABCDE, 20'h00000, 40'h0000000000, LAT_B1,  0);
    run_op("b_group1",  20'h00007, 20'h00010, 40'h0000000070, LAT_B10, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
